// File: rtl/mxint_vector_mult_acc.sv
// Block-floating-point (MXINT) lane-wise multiply that accumulates ACC_BEATS blocks per result.
// Optional feature: define MXINT_VECTOR_MULT_ACC_ROUND_EN for round-half-up exponent alignment.
module mxint_vector_mult_acc #(
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_IN_0_PRECISION_1  = 8,
    parameter int WEIGHT_PRECISION_0     = 8,
    parameter int WEIGHT_PRECISION_1     = 8,
    parameter int BLOCK_SIZE             = 4,
    parameter int ACC_BEATS              = 2,
    parameter int DATA_OUT_0_PRECISION_0 = DATA_IN_0_PRECISION_0 + WEIGHT_PRECISION_0 + $clog2(ACC_BEATS),
    parameter int DATA_OUT_0_PRECISION_1 = ((DATA_IN_0_PRECISION_1 > WEIGHT_PRECISION_1) ?
                                            DATA_IN_0_PRECISION_1 : WEIGHT_PRECISION_1) + 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic signed [DATA_IN_0_PRECISION_0-1:0]   mdata_in_0 [BLOCK_SIZE],
    input  logic signed [DATA_IN_0_PRECISION_1-1:0]   edata_in_0,
    input  logic                                      data_in_0_valid,
    output logic                                      data_in_0_ready,
    input  logic signed [WEIGHT_PRECISION_0-1:0]      mweight [BLOCK_SIZE],
    input  logic signed [WEIGHT_PRECISION_1-1:0]      eweight,
    input  logic                                      weight_valid,
    output logic                                      weight_ready,
    output logic signed [DATA_OUT_0_PRECISION_0-1:0]  mdata_out_0 [BLOCK_SIZE],
    output logic signed [DATA_OUT_0_PRECISION_1-1:0]  edata_out_0,
    output logic                                      data_out_0_valid,
    input  logic                                      data_out_0_ready
);

    localparam int OM    = DATA_OUT_0_PRECISION_0;
    localparam int OE    = DATA_OUT_0_PRECISION_1;
    localparam int PW    = DATA_IN_0_PRECISION_0 + WEIGHT_PRECISION_0;
    localparam int DW    = OE + 1;
    localparam int CNT_W = (ACC_BEATS > 1) ? $clog2(ACC_BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_BEATS - 1);

    typedef enum logic {ACCUM, FULL} state_t;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt;
    logic signed [OM-1:0]   acc [BLOCK_SIZE];
    logic signed [OE-1:0]   eacc;
    logic                   accept, fire, first_beat, last_beat;
    logic signed [OE-1:0]   e_in, e_next;
    logic signed [DW-1:0]   ediff;
    logic                   e_gt;
    logic [DW-1:0]          shamt;
    logic signed [PW-1:0]   prod [BLOCK_SIZE];
    logic signed [OM-1:0]   prod_ext [BLOCK_SIZE];
    logic signed [OM-1:0]   merged [BLOCK_SIZE];

    // Shifts at or beyond the operand width collapse to pure sign fill instead of wrapping.
    function automatic logic signed [OM-1:0] align_shift(input logic signed [OM-1:0] x,
                                                         input logic [DW-1:0] s);
`ifdef MXINT_VECTOR_MULT_ACC_ROUND_EN
        logic signed [OM:0] biased;
`endif
        if (int'(s) >= OM) return {OM{x[OM-1]}};
`ifdef MXINT_VECTOR_MULT_ACC_ROUND_EN
        if (s == '0) return x;
        biased = {x[OM-1], x} + ((OM+1)'(1) << (s - 1'b1));
        return OM'(biased >>> s);
`else
        return x >>> s;
`endif
    endfunction

    assign first_beat = (cnt == '0);
    assign last_beat  = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ACCUM;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (fire && last_beat)
            state_next = FULL;
        else if (state == FULL && data_out_0_ready)
            state_next = ACCUM;
    end

    // A last beat may only land when the output register is free or draining this cycle.
    always_comb begin
        accept           = !last_beat || (state == ACCUM) || data_out_0_ready;
        fire             = data_in_0_valid && weight_valid && accept;
        data_in_0_ready  = weight_valid && accept;
        weight_ready     = data_in_0_valid && accept;
        data_out_0_valid = (state == FULL);
    end

    always_comb begin
        e_in   = OE'(edata_in_0) + OE'(eweight);
        ediff  = DW'(e_in) - DW'(eacc);
        e_gt   = !ediff[DW-1] && (ediff != '0);
        shamt  = e_gt ? ediff : -ediff;
        e_next = (first_beat || e_gt) ? e_in : eacc;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            prod[i]     = PW'(mdata_in_0[i]) * PW'(mweight[i]);
            prod_ext[i] = OM'(prod[i]);
            if (first_beat)
                merged[i] = prod_ext[i];
            else if (e_gt)
                merged[i] = align_shift(acc[i], shamt) + prod_ext[i];
            else
                merged[i] = acc[i] + align_shift(prod_ext[i], shamt);
        end
    end

    // The last beat bypasses acc and lands straight in the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            eacc        <= '0;
            edata_out_0 <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                acc[i]         <= '0;
                mdata_out_0[i] <= '0;
            end
        end else if (fire) begin
            if (last_beat) begin
                mdata_out_0 <= merged;
                edata_out_0 <= e_next;
                cnt         <= '0;
            end else begin
                acc  <= merged;
                eacc <= e_next;
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mxint_vector_mult_acc.sv
// Self-checking bench: table of two-beat vectors with a scoreboard on an ACC_BEATS=2 instance,
// plus hand-written backpressure/reset/rounding sequences and an ACC_BEATS=1 instance.
module tb_mxint_vector_mult_acc;

    localparam int BS  = 4;
    localparam int OM2 = 17;
    localparam int OM1 = 16;
    localparam int OE  = 9;
    localparam int NV  = 5;
`ifdef MXINT_VECTOR_MULT_ACC_ROUND_EN
    localparam int RND_EXP = 2;
`else
    localparam int RND_EXP = 1;
`endif

    typedef logic [BS-1:0][7:0] lanes_t;

    typedef struct packed {
        lanes_t      d0, w0, d1, w1;
        logic [7:0]  ed0, ew0, ed1, ew1;
        logic [BS-1:0][OM2-1:0] om;
        logic [OE-1:0] oe;
    } vec_t;

    typedef struct packed {
        logic [BS-1:0][OM2-1:0] m;
        logic [OE-1:0]          e;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic signed [7:0]     md [BS];
    logic signed [7:0]     mw [BS];
    logic signed [7:0]     ed, ew;
    logic                  din_valid, din_ready, w_valid, w_ready;
    logic signed [OM2-1:0] mo [BS];
    logic signed [OE-1:0]  eo;
    logic                  out_valid, out_ready;

    logic signed [7:0]     u1_md [BS];
    logic signed [7:0]     u1_mw [BS];
    logic signed [7:0]     u1_ed, u1_ew;
    logic                  u1_din_valid, u1_din_ready, u1_w_valid, u1_w_ready;
    logic signed [OM1-1:0] u1_mo [BS];
    logic signed [OE-1:0]  u1_eo;
    logic                  u1_out_valid, u1_out_ready;

    mxint_vector_mult_acc #(.BLOCK_SIZE(BS), .ACC_BEATS(2)) dut (
        .clk(clk), .rst(rst),
        .mdata_in_0(md), .edata_in_0(ed), .data_in_0_valid(din_valid), .data_in_0_ready(din_ready),
        .mweight(mw), .eweight(ew), .weight_valid(w_valid), .weight_ready(w_ready),
        .mdata_out_0(mo), .edata_out_0(eo), .data_out_0_valid(out_valid), .data_out_0_ready(out_ready)
    );

    mxint_vector_mult_acc #(.BLOCK_SIZE(BS), .ACC_BEATS(1)) dut1 (
        .clk(clk), .rst(rst),
        .mdata_in_0(u1_md), .edata_in_0(u1_ed), .data_in_0_valid(u1_din_valid), .data_in_0_ready(u1_din_ready),
        .mweight(u1_mw), .eweight(u1_ew), .weight_valid(u1_w_valid), .weight_ready(u1_w_ready),
        .mdata_out_0(u1_mo), .edata_out_0(u1_eo), .data_out_0_valid(u1_out_valid), .data_out_0_ready(u1_out_ready)
    );

    vec_t  vecs [NV];
    string vec_name [NV];
    exp_t  sb [$];
    exp_t  mon_x;
    int    checks = 0;
    int    failures = 0;
    int    handshakes = 0;

    task automatic check_output(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic drive_beat(input lanes_t d, input lanes_t w, input logic [7:0] e_d, input logic [7:0] e_w);
        for (int i = 0; i < BS; i++) begin
            md[i] = d[i];
            mw[i] = w[i];
        end
        ed = e_d;
        ew = e_w;
        din_valid = 1'b1;
        w_valid   = 1'b1;
    endtask

    task automatic send_beat(input lanes_t d, input lanes_t w, input logic [7:0] e_d, input logic [7:0] e_w);
        int waited = 0;
        drive_beat(d, w, e_d, e_w);
        @(negedge clk);
        while (!(din_ready && w_ready) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            checks++;
            failures++;
            $display("[TB] FAIL send_timeout: got no ready expected ready within 50 cycles");
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        w_valid   = 1'b0;
    endtask

    task automatic apply_stimulus(input int k);
        send_beat(vecs[k].d0, vecs[k].w0, vecs[k].ed0, vecs[k].ew0);
        sb.push_back('{m: vecs[k].om, e: vecs[k].oe});
        send_beat(vecs[k].d1, vecs[k].w1, vecs[k].ed1, vecs[k].ew1);
    endtask

    // Scoreboard: every output handshake pops one expected result.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            handshakes++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL sb_unexpected: got output with empty queue expected none");
            end else begin
                mon_x = sb.pop_front();
                for (int i = 0; i < BS; i++)
                    check_output($sformatf("sb_lane%0d", i), mo[i], $signed(mon_x.m[i]));
                check_output("sb_exp", eo, $signed(mon_x.e));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        vecs[0] = '{d0: {-8'sd1, 8'sd4, -8'sd3, 8'sd2}, w0: {8'sd7, -8'sd5, 8'sd3, 8'sd5}, ed0: 8'sd0, ew0: 8'sd0,
                    d1: {8'sd2, 8'sd3, 8'sd1, 8'sd1}, w1: {8'sd2, 8'sd3, -8'sd4, 8'sd5}, ed1: 8'sd0, ew1: 8'sd0,
                    om: {-17'sd3, -17'sd11, -17'sd13, 17'sd15}, oe: 9'sd0};
        vecs[1] = '{d0: {-8'sd4, 8'sd1, -8'sd8, 8'sd4}, w0: {8'sd1, 8'sd1, 8'sd2, 8'sd4}, ed0: 8'sd1, ew0: 8'sd1,
                    d1: {8'sd1, 8'sd0, 8'sd1, 8'sd2}, w1: {-8'sd1, 8'sd5, 8'sd1, 8'sd2}, ed1: 8'sd3, ew1: 8'sd1,
                    om: {-17'sd2, 17'sd0, -17'sd3, 17'sd8}, oe: 9'sd4};
        vecs[2] = '{d0: {8'sd1, 8'sd0, 8'sd1, 8'sd2}, w0: {-8'sd1, 8'sd5, 8'sd1, 8'sd2}, ed0: 8'sd3, ew0: 8'sd1,
                    d1: {-8'sd4, 8'sd1, -8'sd8, 8'sd4}, w1: {8'sd1, 8'sd1, 8'sd2, 8'sd4}, ed1: 8'sd1, ew1: 8'sd1,
                    om: {-17'sd2, 17'sd0, -17'sd3, 17'sd8}, oe: 9'sd4};
        vecs[3] = '{d0: {-8'sd1, 8'sd0, -8'sd50, 8'sd50}, w0: {8'sd1, 8'sd7, 8'sd50, 8'sd50}, ed0: -8'sd100, ew0: -8'sd100,
                    d1: {8'sd0, -8'sd2, 8'sd3, 8'sd3}, w1: {8'sd9, 8'sd5, 8'sd3, 8'sd3}, ed1: 8'sd100, ew1: 8'sd100,
                    om: {-17'sd1, -17'sd10, 17'sd8, 17'sd9}, oe: 9'sd200};
        vecs[4] = '{d0: {8'sd0, 8'sd127, 8'sh80, 8'sh80}, w0: {8'sd0, 8'sd127, 8'sd127, 8'sh80}, ed0: 8'sd5, ew0: -8'sd3,
                    d1: {8'sd5, 8'sh80, 8'sh80, 8'sh80}, w1: {8'sd0, 8'sh80, 8'sd127, 8'sh80}, ed1: 8'sd5, ew1: -8'sd3,
                    om: {17'sd0, 17'sd32513, -17'sd32512, 17'sd32768}, oe: 9'sd2};
        vec_name = '{"equal_exp", "rising_exp", "falling_exp", "huge_shift", "extreme_mant"};

        rst = 1'b0;
        din_valid = 1'b0; w_valid = 1'b0; out_ready = 1'b1; ed = '0; ew = '0;
        u1_din_valid = 1'b0; u1_w_valid = 1'b0; u1_out_ready = 1'b1; u1_ed = '0; u1_ew = '0;
        for (int i = 0; i < BS; i++) begin
            md[i] = '0; mw[i] = '0; u1_md[i] = '0; u1_mw[i] = '0;
        end

        #12;
        check_output("rst_valid", out_valid, 0);
        for (int i = 0; i < BS; i++) check_output("rst_mant", mo[i], 0);
        check_output("rst_exp", eo, 0);
        check_output("rst_u1_valid", u1_out_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < NV; k++) begin
            $display("[TB] vector %s", vec_name[k]);
            apply_stimulus(k);
        end
        repeat (3) @(posedge clk);
        #1;
        check_output("single_pulse_valid", out_valid, 0);

        sb.push_back('{m: {17'sd0, 17'sd0, 17'sd0, 17'(RND_EXP)}, e: 9'sd2});
        send_beat({8'sd0, 8'sd0, 8'sd0, 8'sd2}, {8'sd0, 8'sd0, 8'sd0, 8'sd3}, 8'sd0, 8'sd0);
        send_beat('0, '0, 8'sd1, 8'sd1);
        repeat (2) @(posedge clk);
        #1;

        out_ready = 1'b0;
        apply_stimulus(0);
        check_output("bp_full_valid", out_valid, 1);
        drive_beat(vecs[1].d0, vecs[1].w0, vecs[1].ed0, vecs[1].ew0);
        #1;
        check_output("bp_nonlast_ready", din_ready, 1);
        @(posedge clk);
        #1;
        sb.push_back('{m: vecs[1].om, e: vecs[1].oe});
        drive_beat(vecs[1].d1, vecs[1].w1, vecs[1].ed1, vecs[1].ew1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_output("bp_last_din_ready", din_ready, 0);
            check_output("bp_last_w_ready", w_ready, 0);
        end
        check_output("bp_hold_mant", mo[0], 15);
        check_output("bp_hold_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check_output("bp_release_ready", din_ready, 1);
        @(posedge clk);
        #1;
        din_valid = 1'b0; w_valid = 1'b0;
        check_output("bp_new_valid", out_valid, 1);
        check_output("bp_new_mant", mo[0], 8);
        check_output("bp_new_exp", eo, 4);
        repeat (2) @(posedge clk);
        #1;

        out_ready = 1'b0;
        apply_stimulus(0);
        send_beat({8'sd0, 8'sd0, 8'sd0, 8'sd7}, {8'sd0, 8'sd0, 8'sd0, 8'sd1}, 8'sd0, 8'sd0);
        #2;
        rst = 1'b0;
        #1;
        check_output("midrst_valid", out_valid, 0);
        check_output("midrst_mant", mo[0], 0);
        check_output("midrst_exp", eo, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        sb.push_back('{m: {17'sd0, 17'sd0, 17'sd0, 17'sd8}, e: 9'sd0});
        send_beat({8'sd0, 8'sd0, 8'sd0, 8'sd7}, {8'sd0, 8'sd0, 8'sd0, 8'sd1}, 8'sd0, 8'sd0);
        send_beat({8'sd0, 8'sd0, 8'sd0, 8'sd1}, {8'sd0, 8'sd0, 8'sd0, 8'sd1}, 8'sd0, 8'sd0);
        repeat (3) @(posedge clk);
        #1;

        u1_md[0] = 8'sd3;   u1_mw[0] = -8'sd2;
        u1_md[1] = -8'sd5;  u1_mw[1] = 8'sd4;
        u1_md[2] = 8'sd0;   u1_mw[2] = 8'sd9;
        u1_md[3] = 8'sd127; u1_mw[3] = 8'sh80;
        u1_ed = 8'sd1; u1_ew = 8'sd2;
        u1_out_ready = 1'b0;
        u1_din_valid = 1'b1; u1_w_valid = 1'b1;
        #1;
        check_output("u1_idle_ready", u1_din_ready, 1);
        @(posedge clk);
        #1;
        check_output("u1_valid", u1_out_valid, 1);
        check_output("u1_lane0", u1_mo[0], -6);
        check_output("u1_lane1", u1_mo[1], -20);
        check_output("u1_lane2", u1_mo[2], 0);
        check_output("u1_lane3", u1_mo[3], -16256);
        check_output("u1_exp", u1_eo, 3);
        u1_md[0] = 8'sd5; u1_mw[0] = 8'sd5; u1_ed = 8'sd0; u1_ew = -8'sd1;
        #1;
        check_output("u1_stall_ready", u1_din_ready, 0);
        @(posedge clk);
        #1;
        check_output("u1_hold", u1_mo[0], -6);
        u1_out_ready = 1'b1;
        #1;
        check_output("u1_release_ready", u1_w_ready, 1);
        @(posedge clk);
        #1;
        u1_din_valid = 1'b0; u1_w_valid = 1'b0;
        check_output("u1_second_mant", u1_mo[0], 25);
        check_output("u1_second_exp", u1_eo, -1);
        @(posedge clk);
        #1;
        check_output("u1_drained_valid", u1_out_valid, 0);

        check_output("sb_drained", sb.size(), 0);
        check_output("handshake_count", handshakes, 9);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mxint_vector_mult_acc.md
MXINT_VECTOR_MULT_ACC -- requirements
Module: mxint_vector_mult_acc

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 8, data mantissa width.
REQ-002 SHALL have parameter DATA_IN_0_PRECISION_1, default 8, data exponent width.
REQ-003 SHALL have parameter WEIGHT_PRECISION_0, default 8, weight mantissa width.
REQ-004 SHALL have parameter WEIGHT_PRECISION_1, default 8, weight exponent width.
REQ-005 SHALL have parameter BLOCK_SIZE, default 4, lanes per block (>=1).
REQ-006 SHALL have parameter ACC_BEATS, default 2, blocks accumulated per output (>=1; 1 = plain multiply).
REQ-007 SHALL have derived parameter DATA_OUT_0_PRECISION_0 = DATA_IN_0_PRECISION_0 + WEIGHT_PRECISION_0 + $clog2(ACC_BEATS), the output mantissa width (OM).
REQ-008 SHALL have derived parameter DATA_OUT_0_PRECISION_1 = max(DATA_IN_0_PRECISION_1, WEIGHT_PRECISION_1) + 1, the output exponent width (OE).
REQ-009 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-010 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset).
REQ-011 SHALL have port mdata_in_0, input, BLOCK_SIZE x DATA_IN_0_PRECISION_0, signed data mantissas.
REQ-012 SHALL have port edata_in_0, input, DATA_IN_0_PRECISION_1, signed data exponent.
REQ-013 SHALL have ports data_in_0_valid (input, 1) and data_in_0_ready (output, 1).
REQ-014 SHALL have port mweight, input, BLOCK_SIZE x WEIGHT_PRECISION_0, signed weight mantissas.
REQ-015 SHALL have port eweight, input, WEIGHT_PRECISION_1, signed weight exponent.
REQ-016 SHALL have ports weight_valid (input, 1) and weight_ready (output, 1).
REQ-017 SHALL have port mdata_out_0, output, BLOCK_SIZE x OM, signed result mantissas.
REQ-018 SHALL have port edata_out_0, output, OE, signed result exponent.
REQ-019 SHALL have ports data_out_0_valid (output, 1) and data_out_0_ready (input, 1).

Function
REQ-020 Beat accepted iff data_in_0_valid & weight_valid & internal accept; data_in_0_ready = weight_ready = weight_valid/data_in_0_valid respectively ANDed with accept (join semantics, no partial consumption).
REQ-021 Per beat: p[i] = signed(mdata_in_0[i]) * signed(mweight[i]); e = sign-extended edata_in_0 + eweight, computed at OE bits.
REQ-022 Beat counter cnt runs 0..ACC_BEATS-1, increments per accepted beat, wraps to 0 after the last beat.
REQ-023 First beat (cnt==0): acc[i] <= p[i] sign-extended to OM, eacc <= e.
REQ-024 Later beat, e > eacc: acc[i] <= (acc[i] >>> (e-eacc)) + p[i], eacc <= e.
REQ-025 Later beat, e <= eacc: acc[i] <= acc[i] + (p[i] >>> (eacc-e)), eacc unchanged.
REQ-026 Shift amounts >= OM SHALL yield the operand's sign fill (0 or -1); no wrap of shift count.
REQ-027 Last beat (cnt==ACC_BEATS-1) SHALL write the final accumulated value into the output register instead of acc and set data_out_0_valid the next cycle (latency 1 cycle after last-beat acceptance).
REQ-028 States: ACCUM (output register empty) and FULL (output valid pending); ACCUM->FULL on last-beat accept; FULL->ACCUM on output handshake without simultaneous last-beat accept; FULL stays FULL on simultaneous handshake + last beat (new result loaded).
REQ-029 Accept = 1 for non-last beats in any state; for last beat accept = (state==ACCUM) | data_out_0_ready.
REQ-030 Output data SHALL hold stable while data_out_0_valid & !data_out_0_ready.
REQ-031 ACC_BEATS==1: every beat is a last beat; cnt and acc unused; behaves as a 1-deep registered multiplier.

Reset
REQ-032 On rst low: data_out_0_valid=0, mdata_out_0=0, edata_out_0=0, cnt=0, acc=0, eacc=0, state ACCUM, immediately and asynchronously.
REQ-033 Reset mid-accumulation SHALL discard partial sums; the first beat after release is cnt==0.

Configuration
REQ-034 Macro MXINT_VECTOR_MULT_ACC_ROUND_EN: defined -> alignment shifts of REQ-024/025 round half up (add 2^(s-1) before >>> s, s>0); undefined -> truncating arithmetic shift.

Verification
REQ-035 ACC_BEATS=1: m=3, w=-2, e_d=1, e_w=2 -> next cycle out mantissa -6, exponent 3, valid 1.
REQ-036 ACC_BEATS=2, equal exponents 0: products 10 then 5 -> out 15, exponent 0, one valid pulse.
REQ-037 ACC_BEATS=2: beat1 p=16 e=2, beat2 p=4 e=4 -> out 8, exponent 4; swapped order -> out 8, exponent 4.
REQ-038 data_out_0_ready=0 with FULL: non-last beat accepted, last beat sees ready=0; output held; raise ready -> last beat accepted same cycle, new result next cycle.
REQ-039 Reset asserted after beat1 of ACC_BEATS=2 -> valid=0; post-reset beats 7, 1 (e=0) -> out 8.
REQ-040 ROUND_EN, beat1 p=6 e=0, beat2 p=0 e=2 -> out 2 (defined) vs 1 (undefined), exponent 2.
